facelet_capture: RTL and testbench

FACELET_CAPTURE -- requirements
Module: facelet_capture

---
 rtl/facelet_capture.sv | 243 ++++++++++++++++++++++++
 tb/tb_facelet_capture.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/facelet_capture.sv
// ---------------------------------------------------------------------------
// facelet_capture
//
// Records the nine facelets of one cube face from a colour sensor stream.
// Each capture request waits until the incoming colour has been steady and
// valid for STABLE_CYCLES consecutive cycles, then writes that colour into
// the next free slot of the face buffer.
//
// Parameters:
//   STABLE_CYCLES   consecutive identical valid samples needed (1..65535)
//   TIMEOUT_CYCLES  settle-time limit per facelet (1..2^24-1), only used
//                   when FACELET_CAPTURE_TIMEOUT_EN is defined
//
// Build option:
//   FACELET_CAPTURE_TIMEOUT_EN  when defined, a facelet that never settles
//                               is stored as unknown (3'd7) after
//                               TIMEOUT_CYCLES and error pulses with done.
//                               When undefined, settling waits forever and
//                               error is tied low.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   color[2:0]   sensor colour; 0..5 valid, 6/7 invalid
//   capture      one-cycle request to record the next facelet (IDLE only)
//   clear        discard the face buffer and return to IDLE
//   busy         high while settling or storing
//   done         one-cycle pulse when a slot has been written
//   error        one-cycle pulse with done when the slot was a timeout
//   index[3:0]   number of facelets stored (0..9)
//   face_colors  slot i at bits [3i+2:3i]
//   face_valid   high while all nine slots are filled
// ---------------------------------------------------------------------------
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for capture, buffer not full
// SETTLE | watching the colour stream for a stable run (or timeout)
// STORE  | writing prev_color into slot index, pulsing done
// FULL   | all nine slots written, holding until clear
//
module facelet_capture #(
  parameter int unsigned STABLE_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 6500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  color,
  input  logic        capture,
  input  logic        clear,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  index,
  output logic [26:0] face_colors,
  output logic        face_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    STORE  = 2'd2,
    FULL   = 2'd3
  } state_t;

  localparam logic [15:0] STABLE_TC     = 16'(STABLE_CYCLES);
  localparam logic [2:0]  COLOR_UNKNOWN = 3'd7;
  localparam logic [3:0]  SLOTS         = 4'd9;

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535) begin : g_bad_stable
    $error("facelet_capture: STABLE_CYCLES out of range");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 24'hFFFFFF) begin : g_bad_timeout
    $error("facelet_capture: TIMEOUT_CYCLES out of range");
  end

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  prev_color;
  logic [15:0] stable_cnt;
  logic        done_q;

  logic        color_valid;
  logic        color_match;
  logic        stable_hit;
  logic        timeout_hit;
  logic        start;

  assign color_valid = (color < 3'd6);
  assign color_match = color_valid && (color == prev_color);
  // stable_cnt saturates, so ">=" keeps the exit condition true even if the
  // counter were ever to run past the terminal count.
  assign stable_hit  = (stable_cnt >= STABLE_TC);
  assign start       = capture && (index < SLOTS);

  // -------------------------------------------------------------------------
  // Optional settle timeout
  // -------------------------------------------------------------------------
`ifdef FACELET_CAPTURE_TIMEOUT_EN
  localparam logic [23:0] TIMEOUT_TC = 24'(TIMEOUT_CYCLES - 1);

  logic [23:0] timeout_cnt;
  logic        timed_out;
  logic        error_q;

  assign timeout_hit = (timeout_cnt == TIMEOUT_TC);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      timeout_cnt <= 24'd0;
      timed_out   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      error_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            timeout_cnt <= 24'd0;
            timed_out   <= 1'b0;
          end
        end
        SETTLE: begin
          timeout_cnt <= timeout_cnt + 24'd1;
          // A stable run finishing on the same cycle wins over the timeout.
          if (!stable_hit && timeout_hit) begin
            timed_out <= 1'b1;
          end
        end
        STORE: begin
          error_q <= timed_out;
        end
        default: ;
      endcase
    end
  end

  assign error = error_q;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State register and next-state logic
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (stable_hit || timeout_hit) begin
          state_nxt = STORE;
        end
      end
      STORE: begin
        // index is incremented on this edge; slot 8 is the last one.
        state_nxt = (index == (SLOTS - 4'd1)) ? FULL : IDLE;
      end
      FULL: begin
        state_nxt = FULL;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (clear) begin
      state_nxt = IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // Settle tracking and face buffer
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_color  <= 3'd0;
      stable_cnt  <= 16'd0;
      index       <= 4'd0;
      face_colors <= '1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        // Also cancels a STORE in flight: no slot write, no done.
        prev_color  <= 3'd0;
        stable_cnt  <= 16'd0;
        index       <= 4'd0;
        face_colors <= '1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              prev_color <= color;
              stable_cnt <= 16'd0;
            end
          end
          SETTLE: begin
            if (stable_hit) begin
              // Hold prev_color: it is the value about to be stored.
              stable_cnt <= stable_cnt;
            end else if (timeout_hit) begin
              prev_color <= COLOR_UNKNOWN;
            end else if (color_match) begin
              if (stable_cnt != 16'hFFFF) begin
                stable_cnt <= stable_cnt + 16'd1;
              end
            end else begin
              stable_cnt <= 16'd0;
              prev_color <= color;
            end
          end
          STORE: begin
            for (int i = 0; i < 9; i++) begin
              if (index == 4'(i)) begin
                face_colors[3*i +: 3] <= prev_color;
              end
            end
            index  <= index + 4'd1;
            done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign done       = done_q;
  assign busy       = (state == SETTLE) || (state == STORE);
  assign face_valid = (state == FULL);

endmodule

// File: tb/tb_facelet_capture.sv
// Self-checking bench for facelet_capture (STABLE_CYCLES=4, TIMEOUT_CYCLES=20).
// The reference model predicts the done cycle from the colour sequence
// alone: a facelet settles at the first edge k whose last STABLE+1 samples
// are identical and valid; done follows two edges later. With the timeout
// build a facelet that has not settled by then completes at TIMEOUT+1 as 7.
module tb_facelet_capture;

  localparam int S           = 4;
  localparam int T           = 20;
  localparam int SEQ_LEN     = 80;
  localparam int NO_DONE_RUN = 60;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  color;
  logic        capture;
  logic        clear;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  index;
  logic [26:0] face_colors;
  logic        face_valid;

  int checks = 0;
  int errors = 0;

  int         exp_slot [9];
  int         exp_index;
  logic [2:0] seq [SEQ_LEN];
  int         m_d;
  int         m_v;
  int         m_err;

  facelet_capture #(
    .STABLE_CYCLES (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .color      (color),
    .capture    (capture),
    .clear      (clear),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .index      (index),
    .face_colors(face_colors),
    .face_valid (face_valid)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 9; i++) exp_slot[i] = 7;
    exp_index = 0;
  endtask

  function automatic logic [26:0] face_word();
    logic [26:0] w;
    w = '1;
    for (int i = 0; i < 9; i++) w[3*i +: 3] = 3'(exp_slot[i]);
    return w;
  endfunction

  task automatic model_predict();
    logic run_ok;
    m_d   = -1;
    m_v   = 7;
    m_err = 0;
    for (int k = S; k < SEQ_LEN; k++) begin
      run_ok = 1'b1;
      for (int j = k - S; j <= k; j++) begin
        if (seq[j] != seq[k] || seq[k] >= 3'd6) run_ok = 1'b0;
      end
      if (run_ok) begin
        m_d = k + 2;
        m_v = int'(seq[k]);
        break;
      end
    end
`ifdef FACELET_CAPTURE_TIMEOUT_EN
    if (m_d < 0 || m_d > T + 1) begin
      m_d   = T + 1;
      m_v   = 7;
      m_err = 1;
    end
`endif
  endtask

  task automatic fill_const(input int c);
    for (int i = 0; i < SEQ_LEN; i++) seq[i] = 3'(c);
  endtask

  task automatic fill_random(input int mode);
    int         n;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] tail;
    logic [2:0] inv;
    a    = 3'($urandom_range(0, 5));
    b    = 3'($urandom_range(0, 5));
    tail = 3'($urandom_range(0, 5));
    inv  = 3'($urandom_range(6, 7));
    n    = $urandom_range(0, 15);
    for (int i = 0; i < SEQ_LEN; i++) begin
      case (mode)
        0, 1, 2, 3: seq[i] = a;
        4, 5:       seq[i] = (i < n) ? ((i % 2 != 0) ? b : a) : tail;
        6, 7, 8:    seq[i] = (i < n) ? 3'($urandom_range(0, 7)) : tail;
        default:    seq[i] = (i < n) ? 3'($urandom_range(0, 7)) : inv;
      endcase
    end
  endtask

  // Runs one capture on seq[], checking every cycle up to the predicted
  // done. obs_d returns the cycle (after the capture edge) done was seen.
  task automatic run_op(output int obs_d);
    int last;
    model_predict();
    color   = seq[0];
    capture = 1'b1;
    step();
    capture = 1'b0;
    obs_d   = -1;
    last    = (m_d >= 0) ? m_d : NO_DONE_RUN;
    for (int k = 0; k <= last; k++) begin
      if (done === 1'b1 && obs_d < 0) obs_d = k;
      if (k == m_d) begin
        exp_slot[exp_index] = m_v;
        exp_index++;
      end
      check("done", int'(done), int'(k == m_d));
      check("error", int'(error), (k == m_d) ? m_err : 0);
      check("busy", int'(busy), int'((m_d < 0) || (k < m_d)));
      if (k == m_d) begin
        check("index", int'(index), exp_index);
        check("face", int'(face_colors), int'(face_word()));
        check("face_valid", int'(face_valid), int'(exp_index == 9));
      end
      if (k < last) begin
        color   = seq[k+1];
        capture = 1'($urandom_range(0, 1));
        step();
      end
    end
    capture = 1'b0;
    if (m_d < 0) begin
      clear = 1'b1;
      step();
      clear = 1'b0;
      model_clear();
      check("nd_clr_index", int'(index), 0);
      check("nd_clr_busy", int'(busy), 0);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_clear();
  endtask

  initial begin
    int od;
    int nine [9];
    reset   = 1'b1;
    clear   = 1'b0;
    capture = 1'b0;
    color   = 3'd0;
    model_clear();
    step();
    step();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_index", int'(index), 0);
    check("rst_face", int'(face_colors), 27'h7FFFFFF);
    check("rst_valid", int'(face_valid), 0);
    reset = 1'b0;
    step();

    // Constant colour 3: done six cycles after the capture edge.
    fill_const(3);
    run_op(od);
    check("const_latency", od, 6);
    check("const_slot0", int'(face_colors[2:0]), 3);
    check("const_index", int'(index), 1);
    do_clear();

    // 2,5,2,5... for ten samples, then 5 held: last change at sample 9.
    for (int i = 0; i < SEQ_LEN; i++) seq[i] = (i < 10) ? ((i % 2 != 0) ? 3'd5 : 3'd2) : 3'd5;
    run_op(od);
    check("toggle_latency", od, 15);
    check("toggle_slot0", int'(face_colors[2:0]), 5);
    do_clear();

    // Nine facelets fill the face.
    nine = '{0, 1, 2, 3, 4, 5, 0, 1, 2};
    for (int n = 0; n < 9; n++) begin
      fill_const(nine[n]);
      run_op(od);
    end
    check("full_face", int'(face_colors), 27'o210543210);
    check("full_valid", int'(face_valid), 1);
    check("full_index", int'(index), 9);
    capture = 1'b1;
    step();
    capture = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("full_no_done", int'(done), 0);
      check("full_no_busy", int'(busy), 0);
      step();
    end
    check("full_hold", int'(face_colors), 27'o210543210);
    do_clear();
    check("clr_index", int'(index), 0);
    check("clr_face", int'(face_colors), 27'h7FFFFFF);
    check("clr_valid", int'(face_valid), 0);

    // Clear three edges into a settle, with two slots already stored.
    fill_const(1);
    run_op(od);
    fill_const(4);
    run_op(od);
    fill_const(2);
    color   = 3'd2;
    capture = 1'b1;
    step();
    capture = 1'b0;
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_clear();
    check("midclr_busy", int'(busy), 0);
    check("midclr_index", int'(index), 0);
    check("midclr_face", int'(face_colors), 27'h7FFFFFF);
    step();
    check("midclr_busy4", int'(busy), 0);
    check("midclr_index4", int'(index), 0);
    for (int k = 0; k < 8; k++) begin
      check("midclr_no_done", int'(done), 0);
      step();
    end

    // Clear on the STORE edge cancels the write.
    fill_const(5);
    run_op(od);
    color   = 3'd3;
    capture = 1'b1;
    step();
    capture = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("st_clr_busy_pre", int'(busy), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_clear();
    check("st_clr_done", int'(done), 0);
    check("st_clr_index", int'(index), 0);
    check("st_clr_face", int'(face_colors), 27'h7FFFFFF);
    step();
    check("st_clr_done2", int'(done), 0);

    // Reset on the STORE edge cancels the write.
    fill_const(0);
    run_op(od);
    color   = 3'd4;
    capture = 1'b1;
    step();
    capture = 1'b0;
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
    check("st_rst_done", int'(done), 0);
    check("st_rst_index", int'(index), 0);
    check("st_rst_face", int'(face_colors), 27'h7FFFFFF);
    check("st_rst_busy", int'(busy), 0);
    step();
    check("st_rst_done2", int'(done), 0);

    // Colour 7 held: timeout store, or endless settle without the timeout.
    fill_const(7);
    run_op(od);
`ifdef FACELET_CAPTURE_TIMEOUT_EN
    check("timeout_latency", od, 21);
    check("timeout_slot0", int'(face_colors[2:0]), 7);
`else
    check("no_timeout_done", od, -1);
`endif

    // Randomized captures.
    for (int it = 0; it < 40; it++) begin
      if (exp_index == 9) begin
        check("rnd_full_valid", int'(face_valid), 1);
        capture = 1'b1;
        step();
        capture = 1'b0;
        check("rnd_full_busy", int'(busy), 0);
        check("rnd_full_done", int'(done), 0);
        do_clear();
      end
      fill_random($urandom_range(0, 9));
      run_op(od);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
